// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / stall controller for a classic five-stage pipeline.
// Produces the pipeline-register enables and bubble clears, freezes the
// pipeline during multi-cycle multiply/divide, and parks in a halted state
// after a halt syscall retires until 'go' is asserted.
module pipeline_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int REG_BITS   = 5,
  parameter int CNT_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rt,
  input  logic                ex_branch_taken,
  input  logic                ex_md_start,
  input  logic                wb_halt,
  input  logic                go,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_clr,
  output logic                idex_clr,
  output logic                md_done,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  // Countdown is loaded with MD_LATENCY-1; MD_LATENCY never exceeds 255.
  localparam logic [7:0] LP_MD_LOAD = 8'(MD_LATENCY - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [7:0]          r_md_cnt;
  logic [7:0]          w_md_cnt_nxt;
  logic                r_md_done;
  logic                r_halted;
  logic [CNT_BITS-1:0] r_stall_cycles;
  logic                w_load_use;
  logic                w_md_finish;

  // Load-use hazard: the load in EX targets a non-zero register that ID reads.
  always_comb begin
    w_load_use = ex_mem_read && (ex_rt != '0) &&
                 ((id_uses_rs && (id_rs == ex_rt)) ||
                  (id_uses_rt && (id_rt == ex_rt)));
  end

  // Next-state and combinational enable/clear decode, highest priority first.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_md_finish  = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_clr     = 1'b0;
    idex_clr     = 1'b0;

    if (!rst) begin
      // Flush both front-end registers while in reset; everything clocks.
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (wb_halt) begin
            w_state_nxt = ST_HALTED;
          end else if (ex_md_start) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            w_state_nxt  = ST_MD_WAIT;
            w_md_cnt_nxt = LP_MD_LOAD;
          end else if (ex_branch_taken) begin
            // Squash the two wrong-path instructions; a coincident load-use
            // hazard belongs to a squashed instruction and is dropped.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (w_load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end
        end

        ST_MD_WAIT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          if (wb_halt) begin
            w_state_nxt  = ST_HALTED;
            w_md_cnt_nxt = '0;
          end else if (r_md_cnt == '0) begin
            w_state_nxt = ST_RUN;
            w_md_finish = 1'b1;
          end else begin
            w_md_cnt_nxt = r_md_cnt - 8'd1;
          end
        end

        ST_HALTED: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          if (!wb_halt && go) begin
            w_state_nxt = ST_RUN;
          end
        end

        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State, countdown, status flags and the saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state        <= ST_RUN;
      r_md_cnt       <= '0;
      r_md_done      <= 1'b0;
      r_halted       <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_cnt  <= w_md_cnt_nxt;
      r_md_done <= w_md_finish;
      r_halted  <= (w_state_nxt == ST_HALTED);
      if (!pc_en && (r_state != ST_HALTED) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_BITS'(1);
      end
    end
  end

  assign md_done      = r_md_done;
  assign halted       = r_halted;
  assign stall_cycles = r_stall_cycles;

endmodule
